// File: rtl/fetch_ctrl.sv
// Fetch sequencer: steps the PC, runs the instruction-memory request/ack
// handshake at the current PC, presents each fetched word to decode over
// valid/ready, and handles jump redirects, halting and retire counting.
//
// Handshake semantics (instr_valid/instr_ready): once instr_valid rises,
// instr_out is held stable and instr_valid stays high until a cycle with
// instr_ready=1 (transfer) or a jump flush. The transfer completes on the
// rising edge of that cycle. instr_valid never depends on instr_ready in
// the same cycle.
module fetch_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [WORD_SIZE-1:0] pc_in,
    output logic [1:0]           pc_sel,
    output logic [WORD_SIZE-1:0] pc_instr,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_out,
    input  logic                 instr_ready,
    input  logic                 jump_valid,
    input  logic [WORD_SIZE-1:0] jump_target,
    output logic                 busy,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] retired,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NEXT = 2'd0;
    localparam logic [1:0] SEL_KEEP = 2'd1;
    localparam logic [1:0] SEL_LOAD = 2'd2;

    state_t               state_q, state_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [WORD_SIZE-1:0] instr_out_q, instr_out_d;
    logic [WORD_SIZE-1:0] retired_q, retired_d;
    logic                 halt_pending_q, halt_pending_d;

    // PC bits above the memory address width are intentionally dropped.
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc_in[WORD_SIZE-1:ADDR_SIZE];

    // State and datapath registers; reset forces IDLE with everything cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            instr_valid_q  <= 1'b0;
            instr_out_q    <= '0;
            retired_q      <= '0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_valid_q  <= instr_valid_d;
            instr_out_q    <= instr_out_d;
            retired_q      <= retired_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    // Next-state, datapath updates and PC/memory control outputs.
    always_comb begin
        state_d        = state_q;
        instr_valid_d  = instr_valid_q;
        instr_out_d    = instr_out_q;
        retired_d      = retired_q;
        // halt_req is sticky from any state until HALT is entered.
        halt_pending_d = halt_pending_q | halt_req;
        pc_sel         = SEL_KEEP;
        mem_req        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (jump_valid) begin
                    // Redirect wins; any data acked this cycle belongs to the
                    // old path and is dropped.
                    pc_sel = SEL_LOAD;
                end else if (mem_ack) begin
                    instr_out_d   = mem_rdata;
                    instr_valid_d = 1'b1;
                    pc_sel        = SEL_NEXT;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (jump_valid) begin
                    // Flush the held word without retiring it.
                    instr_valid_d = 1'b0;
                    pc_sel        = SEL_LOAD;
                    state_d       = FETCH;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    retired_d     = retired_q + 1'b1;
                    if (halt_pending_q || halt_req) begin
                        state_d        = HALT;
                        halt_pending_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_instr    = jump_target;
    assign mem_addr    = pc_in[ADDR_SIZE-1:0];
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign retired     = retired_q;
    assign busy        = (state_q == FETCH) || (state_q == HOLD);
    assign halted      = (state_q == HALT);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: the bench owns a small PC register driven by
// pc_sel/pc_instr, applies a table of per-cycle vectors and then a few
// hand-written sequences (address truncation, asynchronous reset).
module tb_fetch_ctrl;

  localparam int W = 32;
  localparam int A = 14;

  localparam logic [1:0] K = 2'd1;
  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] L = 2'd2;

  logic         clk;
  logic         rst;
  logic         start;
  logic         halt_req;
  logic [W-1:0] pc_in;
  logic [1:0]   pc_sel;
  logic [W-1:0] pc_instr;
  logic         mem_req;
  logic [A-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic         instr_valid;
  logic [W-1:0] instr_out;
  logic         instr_ready;
  logic         jump_valid;
  logic [W-1:0] jump_target;
  logic         busy;
  logic         halted;
  logic [W-1:0] retired;
  logic [1:0]   dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  fetch_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .pc_in       (pc_in),
    .pc_sel      (pc_sel),
    .pc_instr    (pc_instr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment PC register steered by the DUT's selector.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_in <= '0;
    else begin
      case (pc_sel)
        2'd0:    pc_in <= pc_in + 1;
        2'd2:    pc_in <= pc_instr;
        default: pc_in <= pc_in;
      endcase
    end
  end

  typedef struct {
    logic         start;
    logic         hr;
    logic         ack;
    logic [W-1:0] rdata;
    logic         rdy;
    logic         jv;
    logic [W-1:0] jt;
    logic [1:0]   e_sel;
    logic         e_req;
    logic         e_val;
    logic [W-1:0] e_out;
    logic         e_busy;
    logic         e_halted;
    logic [W-1:0] e_ret;
    logic [A-1:0] e_addr;
    logic [1:0]   e_state;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic hr, input logic ack, input logic [W-1:0] rd,
                       input logic rdy, input logic jv, input logic [W-1:0] jt);
    start       = s;
    halt_req    = hr;
    mem_ack     = ack;
    mem_rdata   = rd;
    instr_ready = rdy;
    jump_valid  = jv;
    jump_target = jt;
  endtask

  initial begin
    //          st hr ack rdata         rdy jv jt          sel req val out           busy hlt ret     addr         state
    vec[0]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,     K, 0, 0, 32'h0,        0, 0, 32'd0, 14'h0,   2'd0};
    vec[1]  = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 1, 0, 32'h0,        1, 0, 32'd0, 14'h0,   2'd1};
    vec[2]  = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 1, 0, 32'h0,        1, 0, 32'd0, 14'h0,   2'd1};
    vec[3]  = '{0, 0, 1, 32'hA,        1, 0, 32'h0,     N, 1, 0, 32'h0,        1, 0, 32'd0, 14'h0,   2'd1};
    vec[4]  = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 0, 1, 32'hA,        1, 0, 32'd0, 14'h1,   2'd2};
    vec[5]  = '{0, 0, 1, 32'hB,        0, 0, 32'h0,     N, 1, 0, 32'hA,        1, 0, 32'd1, 14'h1,   2'd1};
    vec[6]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,     K, 0, 1, 32'hB,        1, 0, 32'd1, 14'h2,   2'd2};
    vec[7]  = '{0, 0, 1, 32'h77,       0, 0, 32'h0,     K, 0, 1, 32'hB,        1, 0, 32'd1, 14'h2,   2'd2};
    vec[8]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,     K, 0, 1, 32'hB,        1, 0, 32'd1, 14'h2,   2'd2};
    vec[9]  = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 0, 1, 32'hB,        1, 0, 32'd1, 14'h2,   2'd2};
    vec[10] = '{0, 0, 1, 32'hC,        1, 0, 32'h0,     N, 1, 0, 32'hB,        1, 0, 32'd2, 14'h2,   2'd1};
    vec[11] = '{0, 0, 0, 32'h0,        1, 1, 32'h40,    L, 0, 1, 32'hC,        1, 0, 32'd2, 14'h3,   2'd2};
    vec[12] = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 1, 0, 32'hC,        1, 0, 32'd2, 14'h40,  2'd1};
    vec[13] = '{0, 0, 1, 32'hD,        1, 1, 32'h80,    L, 1, 0, 32'hC,        1, 0, 32'd2, 14'h40,  2'd1};
    vec[14] = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 1, 0, 32'hC,        1, 0, 32'd2, 14'h80,  2'd1};
    vec[15] = '{0, 1, 1, 32'hE,        1, 0, 32'h0,     N, 1, 0, 32'hC,        1, 0, 32'd2, 14'h80,  2'd1};
    vec[16] = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 0, 1, 32'hE,        1, 0, 32'd2, 14'h81,  2'd2};
    vec[17] = '{0, 0, 1, 32'h99,       1, 1, 32'h100,   K, 0, 0, 32'hE,        0, 1, 32'd3, 14'h81,  2'd3};
    vec[18] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,     K, 0, 0, 32'hE,        0, 1, 32'd3, 14'h81,  2'd3};
    vec[19] = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 1, 0, 32'hE,        1, 0, 32'd3, 14'h81,  2'd1};
    vec[20] = '{0, 0, 1, 32'hF,        1, 0, 32'h0,     N, 1, 0, 32'hE,        1, 0, 32'd3, 14'h81,  2'd1};
    vec[21] = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 0, 1, 32'hF,        1, 0, 32'd3, 14'h82,  2'd2};
    vec[22] = '{0, 0, 0, 32'h0,        1, 0, 32'h0,     K, 1, 0, 32'hF,        1, 0, 32'd4, 14'h82,  2'd1};

    // Reset block
    rst = 1'b0;
    drive(0, 0, 0, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_state",   {30'd0, dbg_state}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req},   32'd0);
    check("reset_pc_sel",  {30'd0, pc_sel},    {30'd0, K});
    check("reset_valid",   {31'd0, instr_valid}, 32'd0);
    check("reset_out",     instr_out, 32'd0);
    check("reset_retired", retired,   32'd0);
    check("reset_busy",    {31'd0, busy},   32'd0);
    check("reset_halted",  {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors: drive on the falling edge, compare just after.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].start, vec[i].hr, vec[i].ack, vec[i].rdata, vec[i].rdy, vec[i].jv, vec[i].jt);
      #1;
      check($sformatf("v%0d_pc_sel", i),   {30'd0, pc_sel},      {30'd0, vec[i].e_sel});
      check($sformatf("v%0d_pc_instr", i), pc_instr,             vec[i].jt);
      check($sformatf("v%0d_mem_req", i),  {31'd0, mem_req},     {31'd0, vec[i].e_req});
      check($sformatf("v%0d_valid", i),    {31'd0, instr_valid}, {31'd0, vec[i].e_val});
      check($sformatf("v%0d_instr_out", i), instr_out,           vec[i].e_out);
      check($sformatf("v%0d_busy", i),     {31'd0, busy},        {31'd0, vec[i].e_busy});
      check($sformatf("v%0d_halted", i),   {31'd0, halted},      {31'd0, vec[i].e_halted});
      check($sformatf("v%0d_retired", i),  retired,              vec[i].e_ret);
      check($sformatf("v%0d_mem_addr", i), {18'd0, mem_addr},    {18'd0, vec[i].e_addr});
      check($sformatf("v%0d_state", i),    {30'd0, dbg_state},   {30'd0, vec[i].e_state});
    end

    // Address truncation: redirect to a PC with bits above the address width.
    @(negedge clk);
    drive(0, 0, 0, '0, 1, 1, 32'hFFFF_4005);
    #1;
    check("trunc_pc_sel", {30'd0, pc_sel}, {30'd0, L});
    @(negedge clk);
    drive(0, 0, 0, '0, 1, 0, '0);
    #1;
    check("trunc_mem_addr", {18'd0, mem_addr}, 32'h0000_0005);
    check("trunc_mem_req",  {31'd0, mem_req},  32'd1);

    // Asynchronous reset mid-FETCH, away from any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("areset_mem_req", {31'd0, mem_req},     32'd0);
    check("areset_valid",   {31'd0, instr_valid}, 32'd0);
    check("areset_retired", retired,              32'd0);
    check("areset_state",   {30'd0, dbg_state},   32'd0);
    check("areset_busy",    {31'd0, busy},        32'd0);
    check("areset_pc_sel",  {30'd0, pc_sel},      {30'd0, K});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_idle", {30'd0, dbg_state}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
